// File: rtl/large_number_scheduler_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// large_number_sched_types : shared types/constants for large_number_scheduler
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
package large_number_sched_types;

  localparam int NREQ_DEF   = 4;
  localparam int DATA_W_DEF = 7;
  localparam int STAT_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  typedef logic signed [DATA_W_DEF-1:0] operand_t;

endpackage
`default_nettype wire

// File: rtl/large_number_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// large_number_scheduler_if : requester, shared-unit and response signals
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
interface large_number_scheduler_if
  import large_number_sched_types::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic [DATA_W-1:0]      eval_data;
  logic                   eval_result;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic                   rsp_bit;
  logic                   rsp_ready;

  // master: requesters, shared unit and response consumer
  modport master (
    output req_valid, req_data, eval_result, rsp_ready,
    input  req_ready, eval_data, rsp_valid, rsp_id, rsp_bit
  );

  // slave: the scheduler
  modport slave (
    input  req_valid, req_data, eval_result, rsp_ready,
    output req_ready, eval_data, rsp_valid, rsp_id, rsp_bit
  );

endinterface
`default_nettype wire

// File: rtl/large_number_scheduler_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// large_number_rr_arbiter : combinational round-robin pick starting at ptr_i
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module large_number_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [ID_W-1:0] grant_id_o
);

  logic [ID_W-1:0] idx;
  logic            found;

  // NREQ is a power of two, so the ID_W-bit add wraps naturally
  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    found      = 1'b0;
    idx        = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr_i + ID_W'(k);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_id_o   = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/large_number_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// large_number_scheduler : round-robin sharing of one evaluation unit
// Optional stat counters: LARGE_NUMBER_SCHED_STATS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module large_number_scheduler
  import large_number_sched_types::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  large_number_scheduler_if.slave bus
`ifdef LARGE_NUMBER_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0]       stat_total,
  output logic [STAT_W-1:0]       stat_true
`endif
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_t      state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [DATA_W-1:0] eval_q, eval_d;
  logic              res_q, res_d;
  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   grant_id;

  large_number_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req_i      (bus.req_valid),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      eval_q  <= '0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      eval_q  <= eval_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    eval_d  = eval_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          eval_d  = bus.req_data[int'(grant_id)*DATA_W +: DATA_W];
          owner_d = grant_id;
          state_d = EVAL;
        end
      end
      EVAL: begin
        res_d   = bus.eval_result;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          ptr_d   = owner_q + ID_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // the grant is masked while rst is high so nothing is accepted during reset
  assign bus.req_ready = (state_q == IDLE && !rst) ? grant : '0;
  assign bus.eval_data = eval_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = owner_q;
  assign bus.rsp_bit   = res_q;

`ifdef LARGE_NUMBER_SCHED_STATS_EN
  logic [STAT_W-1:0] total_q, true_q;
  logic              accept;

  assign accept = (state_q == RESP) && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= '0;
      true_q  <= '0;
    end else if (accept) begin
      if (total_q != '1) total_q <= total_q + STAT_W'(1);
      if (res_q && true_q != '1) true_q <= true_q + STAT_W'(1);
    end
  end

  assign stat_total = total_q;
  assign stat_true  = true_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_large_number_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_large_number_scheduler : scoreboard bench for large_number_scheduler
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_large_number_scheduler;

  localparam int NREQ   = 4;
  localparam int DATA_W = 7;
  localparam int ID_W   = 2;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              bitv;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flip;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  large_number_scheduler_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

  // shared unit model: sign bit of the operand, optionally inverted
  assign bus.eval_result = bus.eval_data[DATA_W-1] ^ flip;

`ifdef LARGE_NUMBER_SCHED_STATS_EN
  logic [15:0] stat_total, stat_true;
`endif

  large_number_scheduler #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef LARGE_NUMBER_SCHED_STATS_EN
    ,
    .stat_total (stat_total),
    .stat_true  (stat_true)
`endif
  );

  task automatic test_reset();
    rst = 1'b1;
    flip = 1'b0;
    bus.req_valid = '1;
    bus.req_data = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d want 0", bus.rsp_id); end
    checks++; if (bus.rsp_bit !== 1'b0) begin errors++; $display("FAIL reset_rsp_bit got %b want 0", bus.rsp_bit); end
    checks++; if (bus.eval_data !== 7'h00) begin errors++; $display("FAIL reset_eval_data got %h want 00", bus.eval_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = '0;
  endtask

  task automatic test_single();
    exp_t e;
    bus.req_valid = 4'b0100;
    bus.req_data[2*DATA_W +: DATA_W] = 7'h7B;
    flip = 1'b0;
    e.id = 2'd2; e.data = 7'h7B; e.bitv = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_eval got %b want 0000", bus.req_ready); end
    checks++; if (bus.eval_data !== 7'h7B) begin errors++; $display("FAIL single_eval_data got %h want 7b", bus.eval_data); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp got %b want 0", bus.rsp_valid); end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %b want 1", bus.rsp_valid); end
    e = sb.pop_front();
    checks++; if (bus.rsp_id !== e.id) begin errors++; $display("FAIL single_rsp_id got %0d want %0d", bus.rsp_id, e.id); end
    checks++; if (bus.rsp_bit !== e.bitv) begin errors++; $display("FAIL single_rsp_bit got %b want %b", bus.rsp_bit, e.bitv); end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop got %b want 0", bus.rsp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [DATA_W-1:0] vals [NREQ];
    exp_t e;
    int   cyc;
    vals[0] = 7'h05; vals[1] = 7'h7E; vals[2] = 7'h33; vals[3] = 7'h4C;
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DATA_W +: DATA_W] = vals[i];
    bus.req_valid = '1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int g = 0; g < 8; g++) begin
      e.id = ID_W'(g % NREQ);
      e.data = vals[g % NREQ];
      e.bitv = vals[g % NREQ][DATA_W-1] ^ flip;
      sb.push_back(e);
      @(negedge clk);
      cyc = 1;
      while (bus.req_ready == '0 && cyc < 10) begin @(negedge clk); cyc++; end
      checks++; if (bus.req_ready !== (NREQ'(1) << e.id)) begin errors++; $display("FAIL rr_grant%0d got %b want id %0d", g, bus.req_ready, e.id); end
      if (g > 0) begin
        checks++; if (cyc !== 1) begin errors++; $display("FAIL rr_spacing%0d got %0d extra cycles want 1", g, cyc); end
      end
      @(negedge clk);
      checks++; if (bus.eval_data !== e.data) begin errors++; $display("FAIL rr_eval_data%0d got %h want %h", g, bus.eval_data, e.data); end
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e.id || bus.rsp_bit !== e.bitv) begin
        errors++; $display("FAIL rr_rsp%0d got v%b id%0d b%b want v1 id%0d b%b", g, bus.rsp_valid, bus.rsp_id, bus.rsp_bit, e.id, e.bitv);
      end
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
  endtask

  task automatic test_back_pressure();
    exp_t e;
    bus.rsp_ready = 1'b0;
    flip = 1'b1;
    bus.req_valid = 4'b0010;
    bus.req_data[1*DATA_W +: DATA_W] = 7'h2A;
    bus.req_data[3*DATA_W +: DATA_W] = 7'h61;
    e.id = 2'd1; e.data = 7'h2A; e.bitv = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant got %b want 0010", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 4'b1011;
    @(negedge clk);
    @(negedge clk);
    e = sb.pop_front();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e.id || bus.rsp_bit !== e.bitv || bus.req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_hold%0d got v%b id%0d b%b rdy%b want v1 id%0d b%b rdy0000", c, bus.rsp_valid, bus.rsp_id, bus.rsp_bit, bus.req_ready, e.id, e.bitv);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL bp_next_grant got %b want 1000", bus.req_ready); end
    e.id = 2'd3; e.data = 7'h61; e.bitv = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e.id || bus.rsp_bit !== e.bitv) begin
      errors++; $display("FAIL bp_next_rsp got v%b id%0d b%b want v1 id%0d b%b", bus.rsp_valid, bus.rsp_id, bus.rsp_bit, e.id, e.bitv);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_boundary();
    logic [DATA_W-1:0] ops [2];
    exp_t e;
    ops[0] = 7'h40; ops[1] = 7'h3F;
    flip = 1'b0;
    for (int b = 0; b < 2; b++) begin
      e.id = ID_W'(b); e.data = ops[b]; e.bitv = ops[b][DATA_W-1];
      sb.push_back(e);
      bus.req_valid = NREQ'(1) << b;
      bus.req_data[b*DATA_W +: DATA_W] = ops[b];
      @(negedge clk);
      checks++; if (bus.req_ready !== (NREQ'(1) << b)) begin errors++; $display("FAIL bound_grant%0d got %b want id %0d", b, bus.req_ready, b); end
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      checks++; if (bus.eval_data !== e.data) begin errors++; $display("FAIL bound_eval_data%0d got %h want %h", b, bus.eval_data, e.data); end
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e.id || bus.rsp_bit !== e.bitv) begin
        errors++; $display("FAIL bound_rsp%0d got v%b id%0d b%b want v1 id%0d b%b", b, bus.rsp_valid, bus.rsp_id, bus.rsp_bit, e.id, e.bitv);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_resp();
    exp_t e;
    int   cyc;
    flip = 1'b0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DATA_W +: DATA_W] = 7'(8'h11 * (i + 1));
    bus.req_valid = '1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL rr_pre_reset_grant got %b want 0100", bus.req_ready); end
    cyc = 0;
    while (bus.rsp_valid !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rst_resp_reach got %b want 1", bus.rsp_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL rst_resp_drop got v%b rdy%b want v0 rdy0000", bus.rsp_valid, bus.req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant got %b want 0001", bus.req_ready); end
    e.id = 2'd0; e.data = 7'h11; e.bitv = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e.id || bus.rsp_bit !== e.bitv) begin
      errors++; $display("FAIL rst_after_rsp got v%b id%0d b%b want v1 id%0d b%b", bus.rsp_valid, bus.rsp_id, bus.rsp_bit, e.id, e.bitv);
    end
    @(posedge clk); #1;
  endtask

`ifdef LARGE_NUMBER_SCHED_STATS_EN
  task automatic test_stats();
    logic [DATA_W-1:0] ops [5];
    ops[0] = 7'h40; ops[1] = 7'h01; ops[2] = 7'h7F; ops[3] = 7'h55; ops[4] = 7'h2B;
    flip = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int s = 0; s < 5; s++) begin
      bus.req_data[0 +: DATA_W] = ops[s];
      bus.req_valid = 4'b0001;
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (stat_total !== 16'd5) begin errors++; $display("FAIL stat_total got %0d want 5", stat_total); end
    checks++; if (stat_true !== 16'd3) begin errors++; $display("FAIL stat_true got %0d want 3", stat_true); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_boundary();
    test_reset_resp();
`ifdef LARGE_NUMBER_SCHED_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
